// File: rtl/ysyx_22050368_issue_ctrl.sv
// Decode-to-execute issue controller: tracks in-flight long-latency destinations and holds issue on hazards.
// Optional macro ISSUE_CTRL_WB_BYPASS_EN lets a same-cycle writeback unblock a dependent instruction.
module ysyx_22050368_issue_ctrl #(
    parameter int RFIDX_WIDTH     = 5,
    parameter int NREG            = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dec_valid,
    output logic                   dec_ready,
    input  logic                   dec_rs1en,
    input  logic                   dec_rs2en,
    input  logic [RFIDX_WIDTH-1:0] dec_rs1idx,
    input  logic [RFIDX_WIDTH-1:0] dec_rs2idx,
    input  logic                   dec_rdwen,
    input  logic [RFIDX_WIDTH-1:0] dec_rdidx,
    input  logic                   dec_long,
    output logic                   iss_valid,
    input  logic                   iss_ready,
    input  logic                   wb_valid,
    input  logic [RFIDX_WIDTH-1:0] wb_rdidx,
    input  logic                   flush,
    output logic [3:0]             outstanding,
    output logic [1:0]             stall_reason,
    output logic [CNT_WIDTH-1:0]   stall_cnt,
    output logic                   sb_err
);

    // Handshake: an instruction transfers (fires) in a cycle where iss_valid and iss_ready are both high;
    // dec_ready mirrors that transfer back to decode, so neither side may depend on the other's ready.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HAZ  = 2'd1,
        ST_FULL = 2'd2,
        ST_BUSY = 2'd3
    } state_t;

    logic [NREG-1:0]      r_pending;
    logic [3:0]           r_outstanding;
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic                 r_sb_err;

    logic [NREG-1:0]      w_pend_eff;
    logic [NREG-1:0]      w_pend_nxt;
    logic [3:0]           w_out_eff;
    logic                 w_wb_hit;
    logic                 w_hazard;
    logic                 w_full;
    logic                 w_fire;
    logic                 w_set;

    assign w_wb_hit = wb_valid & r_pending[wb_rdidx];

`ifdef ISSUE_CTRL_WB_BYPASS_EN
    always_comb begin
        w_pend_eff = r_pending;
        if (wb_valid) begin
            w_pend_eff[wb_rdidx] = 1'b0;
        end
    end
    assign w_out_eff = r_outstanding - {3'b000, w_wb_hit};
`else
    assign w_pend_eff = r_pending;
    assign w_out_eff  = r_outstanding;
`endif

    assign w_hazard = (dec_rs1en & w_pend_eff[dec_rs1idx])
                    | (dec_rs2en & w_pend_eff[dec_rs2idx])
                    | (dec_rdwen & w_pend_eff[dec_rdidx]);
    assign w_full   = dec_long & dec_rdwen & (w_out_eff == 4'(MAX_OUTSTANDING));

    // Gating with rst_n keeps both handshake outputs low for the whole reset window.
    assign iss_valid = rst_n & dec_valid & ~w_hazard & ~w_full & ~flush;
    assign dec_ready = iss_valid & iss_ready;
    assign w_fire    = dec_ready;
    assign w_set     = w_fire & dec_long & dec_rdwen & (dec_rdidx != '0);

    // Clear before set so a same-index set/clear leaves the bit set.
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_wb_hit) begin
            w_pend_nxt[wb_rdidx] = 1'b0;
        end
        if (w_set) begin
            w_pend_nxt[dec_rdidx] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending     <= '0;
            r_outstanding <= '0;
            r_sb_err      <= 1'b0;
        end else begin
            r_pending     <= w_pend_nxt;
            r_outstanding <= r_outstanding + {3'b000, w_set} - {3'b000, w_wb_hit};
            if (wb_valid && !r_pending[wb_rdidx]) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    // Stall-reason FSM: the state records why the previous cycle failed to fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else if (flush || !dec_valid || w_fire) begin
            r_state <= ST_RUN;
        end else if (w_hazard) begin
            r_state <= ST_HAZ;
        end else if (w_full) begin
            r_state <= ST_FULL;
        end else begin
            r_state <= ST_BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (dec_valid && !w_fire && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign outstanding  = r_outstanding;
    assign stall_reason = r_state;
    assign stall_cnt    = r_stall_cnt;
    assign sb_err       = r_sb_err;

endmodule
